// File: rtl/time_bcd_converter.sv
// Snapshots binary hh:mm:ss and converts each field to two BCD digits by
// serial double dabble. All outputs update together when the conversion completes.
module time_bcd_converter #(
  parameter int unsigned HR_MAX = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] sec_in,
  input  logic [5:0] min_in,
  input  logic [5:0] hr_in,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hr_bcd,
  output logic       busy,
  output logic       done,
  output logic       range_err
);

  localparam logic [5:0] HR_LIM = 6'(HR_MAX);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t     state, state_nx;
  logic [5:0] snap_sec, snap_min, snap_hr;
  logic       snap_err;
  logic [1:0] field;
  logic [2:0] bitcnt;
  logic [5:0] work_bin;
  logic [7:0] work_bcd;
  logic [7:0] sec_sh, min_sh;

  logic [5:0] src_bin;
  logic [7:0] src_bcd;
  logic [3:0] adj_t, adj_u;
  logic [7:0] adj;
  logic [7:0] nbcd;
  logic [5:0] nbin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = CONV;
      CONV:    if (field == 2'd3) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // First bit of each field reloads the binary source and clears the BCD accumulator.
  always_comb begin
    src_bin = work_bin;
    src_bcd = work_bcd;
    if (bitcnt == 3'd0) begin
      src_bcd = '0;
      unique case (field)
        2'd0:    src_bin = snap_sec;
        2'd1:    src_bin = snap_min;
        default: src_bin = snap_hr;
      endcase
    end
    adj_t = (src_bcd[7:4] >= 4'd5) ? 4'(src_bcd[7:4] + 4'd3) : src_bcd[7:4];
    adj_u = (src_bcd[3:0] >= 4'd5) ? 4'(src_bcd[3:0] + 4'd3) : src_bcd[3:0];
    adj   = {adj_t, adj_u};
    nbcd  = (adj << 1) | {7'd0, src_bin[5]};
    nbin  = src_bin << 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_sec  <= '0;
      snap_min  <= '0;
      snap_hr   <= '0;
      snap_err  <= 1'b0;
      field     <= '0;
      bitcnt    <= '0;
      work_bin  <= '0;
      work_bcd  <= '0;
      sec_sh    <= '0;
      min_sh    <= '0;
      sec_bcd   <= '0;
      min_bcd   <= '0;
      hr_bcd    <= '0;
      range_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            snap_sec <= sec_in;
            snap_min <= min_in;
            snap_hr  <= hr_in;
            snap_err <= (sec_in > 6'd59) | (min_in > 6'd59) | (hr_in > HR_LIM);
            field    <= '0;
            bitcnt   <= '0;
          end
        end
        CONV: begin
          if (field == 2'd3) begin
            // hours result is still in the working register at commit time
            sec_bcd   <= sec_sh;
            min_bcd   <= min_sh;
            hr_bcd    <= work_bcd;
            range_err <= snap_err;
          end else begin
            work_bin <= nbin;
            work_bcd <= nbcd;
            if (bitcnt == 3'd5) begin
              bitcnt <= '0;
              field  <= 2'(field + 2'd1);
              if (field == 2'd0) sec_sh <= nbcd;
              if (field == 2'd1) min_sh <= nbcd;
            end else begin
              bitcnt <= 3'(bitcnt + 3'd1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_time_bcd_converter.sv
// Directed bench for time_bcd_converter: a cycle-count model of the visible
// behaviour is compared every cycle, plus literal checks per scenario.
module tb_time_bcd_converter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [5:0] sec_in = '0, min_in = '0, hr_in = '0;
  logic [7:0] sec_bcd, min_bcd, hr_bcd;
  logic       busy, done, range_err;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;

  localparam int HRM = 23;

  time_bcd_converter #(.HR_MAX(HRM)) dut (
    .clk(clk), .reset(reset), .start(start),
    .sec_in(sec_in), .min_in(min_in), .hr_in(hr_in),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hr_bcd(hr_bcd),
    .busy(busy), .done(done), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // Model: mcount = edges since the accepting edge (0 = idle); results appear at count 20.
  int         mcount = 0;
  logic [7:0] m_sec = '0, m_min = '0, m_hr = '0, p_sec, p_min, p_hr;
  logic       m_err = 1'b0, p_err;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mcount = 0;
      m_sec = '0; m_min = '0; m_hr = '0; m_err = 1'b0;
    end else if (mcount == 0) begin
      if (start) begin
        p_sec = to_bcd(int'(sec_in));
        p_min = to_bcd(int'(min_in));
        p_hr  = to_bcd(int'(hr_in));
        p_err = (sec_in > 59) || (min_in > 59) || (int'(hr_in) > HRM);
        mcount = 1;
      end
    end else if (mcount == 20) begin
      mcount = 0;
    end else begin
      mcount++;
      if (mcount == 20) begin
        m_sec = p_sec; m_min = p_min; m_hr = p_hr; m_err = p_err;
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_sec", int'(sec_bcd), int'(m_sec));
    chk("cmp_min", int'(min_bcd), int'(m_min));
    chk("cmp_hr", int'(hr_bcd), int'(m_hr));
    chk("cmp_err", int'(range_err), int'(m_err));
    chk("cmp_busy", int'(busy), int'(mcount != 0));
    chk("cmp_done", int'(done), int'(mcount == 20));
    if (done) done_seen++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic start_conv(input int h, input int m, input int s);
    hr_in = 6'(h); min_in = 6'(m); sec_in = 6'(s);
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // Called 2 time units after edge N+base; returns 2 units after the done edge.
  task automatic wait_done(input int base, output int lat);
    lat = 0;
    for (int k = base + 1; k <= base + 25; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    #1;
  endtask

  task automatic run(input int h, input int m, input int s,
                     input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                     input logic eerr);
    int lat;
    start_conv(h, m, s);
    chk("busy_after_start", int'(busy), 1);
    wait_done(0, lat);
    chk("latency", lat, 19);
    chk("hr_bcd", int'(hr_bcd), int'(eh));
    chk("min_bcd", int'(min_bcd), int'(em));
    chk("sec_bcd", int'(sec_bcd), int'(es));
    chk("range_err", int'(range_err), int'(eerr));
    step(1);
    chk("busy_after_done", int'(busy), 0);
  endtask

  initial begin
    int lat;
    int ds;
    #1 reset = 1'b1;
    #1;
    chk("rst_sec", int'(sec_bcd), 0);
    chk("rst_min", int'(min_bcd), 0);
    chk("rst_hr", int'(hr_bcd), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(range_err), 0);
    @(posedge clk); #2;
    reset = 1'b0;
    step(2);

    run(12, 34, 56, 8'h12, 8'h34, 8'h56, 1'b0);
    run(0, 0, 0, 8'h00, 8'h00, 8'h00, 1'b0);
    run(23, 59, 59, 8'h23, 8'h59, 8'h59, 1'b0);
    run(0, 0, 9, 8'h00, 8'h00, 8'h09, 1'b0);
    run(0, 0, 10, 8'h00, 8'h00, 8'h10, 1'b0);
    step(3);
    run(0, 0, 63, 8'h00, 8'h00, 8'h63, 1'b1);
    run(24, 0, 0, 8'h24, 8'h00, 8'h00, 1'b1);
    run(1, 1, 1, 8'h01, 8'h01, 8'h01, 1'b0);
    run(5, 60, 7, 8'h05, 8'h60, 8'h07, 1'b1);

    // Starts while busy (mid-conversion and in DONE) must be ignored.
    ds = done_seen;
    start_conv(1, 2, 3);
    hr_in = 6'd4; min_in = 6'd5; sec_in = 6'd6;
    step(4);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done(5, lat);
    chk("ignore_latency", lat, 19);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(25);
    chk("ignore_done_count", done_seen - ds, 1);
    chk("ignore_hr", int'(hr_bcd), 8'h01);
    chk("ignore_min", int'(min_bcd), 8'h02);
    chk("ignore_sec", int'(sec_bcd), 8'h03);

    // Reset mid-conversion aborts with no done pulse.
    ds = done_seen;
    start_conv(30, 40, 50);
    step(10);
    reset = 1'b1;
    #1;
    chk("abort_sec", int'(sec_bcd), 0);
    chk("abort_min", int'(min_bcd), 0);
    chk("abort_hr", int'(hr_bcd), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_err", int'(range_err), 0);
    #1;
    step(1);
    reset = 1'b0;
    step(25);
    chk("abort_done_count", done_seen - ds, 0);
    run(7, 8, 9, 8'h07, 8'h08, 8'h09, 1'b0);
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_bcd_converter.md
TIME_BCD_CONVERTER -- requirements
Module: time_bcd_converter

Interface
REQ-001 The block SHALL have parameter HR_MAX, default 23, meaning the largest legal hours value; values above it raise range_err.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  conversion request, sampled on clk rising edge.
REQ-005 The block SHALL have port sec_in  input  6  binary seconds from the seconds counter (legal range 0-59).
REQ-006 The block SHALL have port min_in  input  6  binary minutes from the minutes counter (legal range 0-59).
REQ-007 The block SHALL have port hr_in  input  6  binary hours (legal range 0-HR_MAX).
REQ-008 The block SHALL have port sec_bcd  output  8  seconds as two BCD digits, tens in [7:4], units in [3:0].
REQ-009 The block SHALL have port min_bcd  output  8  minutes as two BCD digits, same packing.
REQ-010 The block SHALL have port hr_bcd  output  8  hours as two BCD digits, same packing.
REQ-011 The block SHALL have port busy  output  1  high while a conversion is in progress.
REQ-012 The block SHALL have port done  output  1  single-cycle pulse marking new results on the BCD outputs.
REQ-013 The block SHALL have port range_err  output  1  high when the last converted snapshot held an out-of-range field.

Function
REQ-014 FSM states SHALL be IDLE, CONV and DONE; IDLE is the only state that accepts start.
REQ-015 In IDLE with start=1, the block SHALL, on that edge, snapshot sec_in, min_in and hr_in into internal registers and enter CONV; input changes after that edge SHALL NOT affect the result.
REQ-016 CONV SHALL convert fields in order seconds, minutes, hours using iterative shift-add-3 (double dabble), one bit per cycle, 6 cycles per field, 18 cycles total.
REQ-017 Each CONV cycle SHALL add 3 to any BCD nibble >= 5, then shift left one bit, bringing in the next input MSB.
REQ-018 Converted seconds and minutes SHALL be held in shadow registers; sec_bcd, min_bcd, hr_bcd and range_err SHALL all update together on the edge that leaves CONV, so the display never sees a partial update.
REQ-019 The edge that leaves CONV SHALL enter DONE; done SHALL be high for exactly the one cycle spent in DONE, followed by unconditional return to IDLE.
REQ-020 Latency: start sampled at edge N -> outputs valid and done=1 after edge N+19.
REQ-021 busy SHALL be 1 in CONV and DONE and 0 in IDLE.
REQ-022 start while busy=1, including the DONE cycle, SHALL be ignored with no queuing.
REQ-023 Out-of-range input SHALL still be converted literally (6-bit max 63 -> 0x63).
REQ-024 range_err SHALL be set for that snapshot if sec>59, min>59, or hr>HR_MAX.
REQ-025 Between conversions, BCD outputs and range_err SHALL hold their last values.

Reset
REQ-026 reset=1 SHALL immediately, independent of clk, force state IDLE, all BCD outputs 8'h00, busy=0, done=0, range_err=0, and clear all snapshot, shadow and iteration registers.
REQ-027 reset asserted mid-conversion SHALL abort it with no done pulse.
REQ-028 After reset deasserts, the first start sampled in IDLE SHALL convert normally.

Verification
REQ-029 Assert reset with no clock edge -> all outputs 0 immediately; busy=0.
REQ-030 hr=12, min=34, sec=56, pulse start at edge N -> busy from N; done=1 only after N+19; hr_bcd=0x12, min_bcd=0x34, sec_bcd=0x56, range_err=0; busy=0 after N+20.
REQ-031 Boundaries: (0,0,0) -> 0x00/0x00/0x00; (23,59,59) -> 0x23/0x59/0x59; sec=9 then sec=10 -> 0x09 then 0x10; range_err=0 in all cases.
REQ-032 sec=63 -> sec_bcd=0x63, range_err=1; next start with hr=24, rest legal -> hr_bcd=0x24, range_err=1; next fully legal start -> range_err=0.
REQ-033 Start with (1,2,3), then change inputs to (4,5,6) and pulse start at N+5 and at the DONE cycle -> single done pulse, outputs 0x01/0x02/0x03.
REQ-034 Assert reset at N+10 of a conversion -> outputs 0x00, no done pulse; then start with (7,8,9) -> 0x07/0x08/0x09 after 19 edges.
